// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port master: arbitrates load responses, queued ALU results
// and ALU bypass onto one registered write port, and tracks outstanding loads.
module reg_writeback_ctrl #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            hazard,
  output logic            rd_wen,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic [31:0]     pending
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {SEL_NONE, SEL_LOAD, SEL_QUEUE, SEL_BYPASS} sel_e;

  logic [4:0]      q_rd   [QDEPTH];
  logic [XLEN-1:0] q_data [QDEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  sel_e        sel;
  logic        q_empty;
  logic        alu_accept;
  logic        enq;
  logic        deq;
  logic [31:0] pending_next;
  logic        rs1_hit, rs2_hit;

  assign q_empty    = (count == '0);
  assign alu_ready  = (count != CW'(QDEPTH));
  assign alu_accept = alu_valid && alu_ready;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = SEL_NONE;
    if (ld_valid && ld_rd != 5'd0)
      sel = SEL_LOAD;
    else if (!q_empty)
      sel = SEL_QUEUE;
    else if (alu_valid && alu_rd != 5'd0)
      sel = SEL_BYPASS;
  end

  // ALU results to x0 are accepted and silently dropped.
  assign enq = alu_accept && (alu_rd != 5'd0) && (sel != SEL_BYPASS);
  assign deq = (sel == SEL_QUEUE);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // NOTE: queue storage has no reset; validity lives entirely in count/rd_ptr,
  // so clearing the payload would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd[wr_ptr]   <= alu_rd;
      q_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wen  <= 1'b0;
      rd_addr <= 5'd0;
      rd_data <= '0;
    end else begin
      rd_wen <= (sel != SEL_NONE);
      unique case (sel)
        SEL_LOAD: begin
          rd_addr <= ld_rd;
          rd_data <= ld_data;
        end
        SEL_QUEUE: begin
          rd_addr <= q_rd[rd_ptr];
          rd_data <= q_data[rd_ptr];
        end
        SEL_BYPASS: begin
          rd_addr <= alu_rd;
          rd_data <= alu_data;
        end
        default: ;
      endcase
    end
  end

  // Clear on the load write, then set, so a same-cycle issue to the same rd wins.
  always_comb begin
    pending_next = pending;
    if (sel == SEL_LOAD)
      pending_next[ld_rd] = 1'b0;
    if (ld_issue && ld_issue_rd != 5'd0)
      pending_next[ld_issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  // A source is busy while a load is outstanding, a queued result targets it,
  // or it is being written this cycle and not yet readable.
  always_comb begin
    rs1_hit = pending[chk_rs1] || (rd_wen && rd_addr == chk_rs1);
    rs2_hit = pending[chk_rs2] || (rd_wen && rd_addr == chk_rs2);
    for (int k = 0; k < QDEPTH; k++) begin
      if (CW'(k) < count) begin
        if (q_rd[rd_ptr + PW'(k)] == chk_rs1) rs1_hit = 1'b1;
        if (q_rd[rd_ptr + PW'(k)] == chk_rs2) rs2_hit = 1'b1;
      end
    end
    hazard = (rs1_hit && chk_rs1 != 5'd0) || (rs2_hit && chk_rs2 != 5'd0);
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed self-checking bench for reg_writeback_ctrl (XLEN=32, QDEPTH=2).
module tb_reg_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  chk_rs1, chk_rs2;
  logic        hazard;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  reg_writeback_ctrl #(.XLEN(32), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_data(rd_data), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    chk_rs1 = 0; chk_rs2 = 0;
  endtask

  task automatic exp_write(input string name, input logic wen, input logic [4:0] addr,
                           input logic [31:0] data);
    checks++;
    if (rd_wen !== wen || rd_addr !== addr || rd_data !== data) begin
      errors++;
      $display("FAIL %s: got wen=%b addr=%0d data=%h, expected wen=%b addr=%0d data=%h",
               name, rd_wen, rd_addr, rd_data, wen, addr, data);
    end
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    tick(); tick();
    rst = 0;
    exp_write("reset_write_port", 1'b0, 5'd0, 32'h0);
    checks++;
    if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending); end
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b expected 1", alu_ready); end
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
  endtask

  task automatic test_bypass();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b expected 1", alu_ready); end
    tick();
    alu_valid = 0;
    exp_write("bypass_write", 1'b1, 5'd5, 32'h1234);
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready_after: got %b expected 1", alu_ready); end
    tick();
    exp_write("bypass_hold", 1'b0, 5'd5, 32'h1234);
  endtask

  task automatic test_collision();
    ld_valid = 1; ld_rd = 3; ld_data = 32'hAAAA;
    alu_valid = 1; alu_rd = 4; alu_data = 32'hBBBB;
    tick();
    idle_inputs();
    exp_write("collision_load_first", 1'b1, 5'd3, 32'hAAAA);
    chk_rs1 = 4; #1;
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL collision_queue_hazard: got %b expected 1", hazard); end
    tick();
    chk_rs1 = 0;
    exp_write("collision_alu_second", 1'b1, 5'd4, 32'hBBBB);
    tick();
    exp_write("collision_idle", 1'b0, 5'd4, 32'hBBBB);
  endtask

  task automatic test_queue_full();
    logic [4:0]  l_rd   [4] = '{5'd10, 5'd11, 5'd12, 5'd13};
    logic [31:0] l_dat  [4] = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    logic [4:0]  a_rd   [4] = '{5'd20, 5'd21, 5'd22, 5'd22};
    logic [31:0] a_dat  [4] = '{32'hC0, 32'hC1, 32'hC2, 32'hC2};
    logic        rdy    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_rd = l_rd[i]; ld_data = l_dat[i];
      alu_valid = 1; alu_rd = a_rd[i]; alu_data = a_dat[i];
      #1;
      checks++;
      if (alu_ready !== rdy[i]) begin
        errors++; $display("FAIL qfull_ready_%0d: got %b expected %b", i, alu_ready, rdy[i]);
      end
      tick();
      exp_write("qfull_load_write", 1'b1, l_rd[i], l_dat[i]);
    end
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    #1;
    checks++;
    if (alu_ready !== 1'b0) begin errors++; $display("FAIL qfull_still_full: got %b expected 0", alu_ready); end
    tick();
    exp_write("qfull_drain0", 1'b1, 5'd20, 32'hC0);
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL qfull_reopen: got %b expected 1", alu_ready); end
    tick();
    alu_valid = 0;
    exp_write("qfull_drain1", 1'b1, 5'd21, 32'hC1);
    tick();
    exp_write("qfull_drain2", 1'b1, 5'd22, 32'hC2);
    tick();
    exp_write("qfull_empty", 1'b0, 5'd22, 32'hC2);
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL qfull_ready_end: got %b expected 1", alu_ready); end
  endtask

  task automatic test_scoreboard();
    ld_issue = 1; ld_issue_rd = 7;
    tick();
    ld_issue = 0;
    chk_rs1 = 7;
    #1;
    checks++;
    if (pending !== 32'h80) begin errors++; $display("FAIL sb_set: got %h expected 00000080", pending); end
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_pending: got %b expected 1", hazard); end
    ld_valid = 1; ld_rd = 7; ld_data = 32'h77;
    tick();
    ld_valid = 0;
    checks++;
    if (pending !== 32'h0) begin errors++; $display("FAIL sb_clear: got %h expected 0", pending); end
    exp_write("sb_load_write", 1'b1, 5'd7, 32'h77);
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_writing: got %b expected 1", hazard); end
    tick();
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL sb_hazard_cleared: got %b expected 0", hazard); end
    chk_rs1 = 0;
    // Same-cycle set and clear of x8.
    ld_issue = 1; ld_issue_rd = 8;
    tick();
    ld_valid = 1; ld_rd = 8; ld_data = 32'h88;
    tick();
    ld_issue = 0; chk_rs2 = 8;
    #1;
    checks++;
    if (pending !== 32'h100) begin errors++; $display("FAIL sb_set_wins: got %h expected 00000100", pending); end
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_rs2: got %b expected 1", hazard); end
    tick();
    ld_valid = 0;
    checks++;
    if (pending !== 32'h0) begin errors++; $display("FAIL sb_final_clear: got %h expected 0", pending); end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    ld_issue = 1; ld_issue_rd = 0;
    ld_valid = 1; ld_rd = 0; ld_data = 32'hBEEF;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b expected 1", alu_ready); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_wen !== 1'b0) begin errors++; $display("FAIL x0_no_write: got %b expected 0", rd_wen); end
    checks++;
    if (pending !== 32'h0) begin errors++; $display("FAIL x0_pending: got %h expected 0", pending); end
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL x0_hazard: got %b expected 0", hazard); end
    tick();
    checks++;
    if (rd_wen !== 1'b0) begin errors++; $display("FAIL x0_not_queued: got %b expected 0", rd_wen); end
  endtask

  task automatic test_reset_mid();
    ld_valid = 1; ld_rd = 1; ld_data = 32'h11;
    alu_valid = 1; alu_rd = 11; alu_data = 32'hB1;
    ld_issue = 1; ld_issue_rd = 9;
    tick();
    ld_issue = 0;
    ld_data = 32'h12; alu_rd = 12; alu_data = 32'hB2;
    tick();
    idle_inputs();
    chk_rs1 = 12;
    #1;
    checks++;
    if (alu_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", alu_ready); end
    checks++;
    if (pending !== 32'h200) begin errors++; $display("FAIL mid_pending: got %h expected 00000200", pending); end
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL mid_hazard: got %b expected 1", hazard); end
    rst = 1;
    tick();
    rst = 0;
    exp_write("mid_reset_port", 1'b0, 5'd0, 32'h0);
    checks++;
    if (pending !== 32'h0) begin errors++; $display("FAIL mid_reset_pending: got %h expected 0", pending); end
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", alu_ready); end
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL mid_reset_hazard: got %b expected 0", hazard); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_write("mid_no_stale", 1'b0, 5'd0, 32'h0);
    end
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    tick();
    idle_inputs();
    exp_write("mid_late_load", 1'b1, 5'd9, 32'h99);
    checks++;
    if (pending !== 32'h0) begin errors++; $display("FAIL mid_late_pending: got %h expected 0", pending); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_queue_full();
    test_scoreboard();
    test_x0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
Write-side master for the 32x32 integer register file. It collects results from the single-cycle ALU path and from the variable-latency load unit, and arbitrates them onto the register file's single write port (rd_wen/rd_addr/rd_data). It also keeps a per-register pending scoreboard for outstanding loads. Decode uses the hazard output to stall instructions whose sources are not yet visible in the register file.

Parameters:
XLEN, 32, data width of all result and write paths
QDEPTH, 2, ALU result queue depth in entries; power of two, >= 2

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
alu_valid  input  1  ALU result offered
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
alu_ready  output  1  ALU result accepted this cycle (queue not full)
ld_issue  input  1  load issued to memory this cycle
ld_issue_rd  input  5  destination of the issued load
ld_valid  input  1  load response; always accepted, no backpressure
ld_rd  input  5  load response destination
ld_data  input  XLEN  load response data
chk_rs1  input  5  decode source 1 to check
chk_rs2  input  5  decode source 2 to check
hazard  output  1  a checked source is not yet readable from the register file
rd_wen  output  1  register file write enable (registered)
rd_addr  output  5  register file write address (registered)
rd_data  output  XLEN  register file write data (registered)
pending  output  32  scoreboard; bit i set = load outstanding to xi

Behaviour:
- Reset: rd_wen=0, rd_addr=0, rd_data=0, pending=0, queue empty, alu_ready=1 on the cycle after reset. Reset mid-operation drops all queued and outstanding state; a load response arriving after reset is still written to the register file but sets no scoreboard bit.
- Handshake: alu_ready = queue not full (combinational). The ALU transfer completes on a posedge where alu_valid && alu_ready. alu_ready does not depend on alu_valid.
- Write-selection priority, evaluated each cycle:
  - ld_valid with ld_rd != 0.
  - Otherwise, the queue head.
  - Otherwise, an ALU bypass: alu_valid, queue empty, alu_rd != 0.
  - The selected entry is registered into rd_*. rd_wen=1 for one cycle per write.
  - If nothing is selected, rd_wen=0 and rd_addr/rd_data hold their values.
- Queue handling:
  - An accepted ALU result that is not bypassed is enqueued.
  - Enqueue and dequeue in the same cycle are both allowed; occupancy is unchanged.
  - Queue order is FIFO.
- Writes to x0 are discarded:
  - ALU results with rd=0 are accepted but never enqueued or written.
  - Load responses with rd=0 are ignored.
  - ld_issue with rd=0 sets nothing.
- Latency: an accepted ALU bypass or load response appears on rd_* at the next posedge. It becomes readable from the register file one further edge later.
- Scoreboard:
  - ld_issue sets pending[ld_issue_rd].
  - A load response that is registered into rd_* clears pending[ld_rd].
  - Set and clear of the same bit in the same cycle: set wins.
  - A response to a non-pending register is still written; pending is unchanged.
  - pending[0] is always 0.
- hazard: combinational. For each nonzero source s in {chk_rs1, chk_rs2}, hazard=1 if any of the following holds:
  - pending[s] is set;
  - a valid queue entry has rd=s;
  - rd_wen && rd_addr==s.
- Ordering: decode stalls on hazard, so write-after-write between the queue and a load to the same rd cannot occur. The block does not check for it.
- Overflow: an ALU result with alu_ready=0 is never lost; the upstream stage holds it.

Test Plan:
- ALU bypass: reset, then alu_valid, alu_rd=5, alu_data=0x1234 with the queue empty -> the next cycle shows rd_wen=1, rd_addr=5, rd_data=0x1234, and alu_ready stays 1.
- Collision: in one cycle ld_valid (ld_rd=3, ld_data=0xAAAA) and alu_valid (alu_rd=4, alu_data=0xBBBB) -> the load is written first (x3=0xAAAA), then x4=0xBBBB the cycle after.
- Queue full: hold ld_valid high for 4 cycles while alu_valid is high with QDEPTH=2 -> alu_ready=0 after 2 accepts; the queue drains in FIFO order once ld_valid drops.
- Scoreboard:
  - ld_issue rd=7 -> pending[7]=1; chk_rs1=7 gives hazard=1.
  - ld_valid rd=7 -> pending[7] clears at the write, and hazard stays 1 while rd_addr==7 && rd_wen.
  - The following cycle hazard=0.
- x0 handling: alu_rd=0, ld_issue rd=0, ld_rd=0 -> rd_wen stays 0, pending=0, hazard=0 for chk_rs1=0.
- Reset mid-operation: queue holds 2 entries and pending[9]=1, then assert rst for 1 cycle -> rd_wen=0, pending=0, alu_ready=1, and no stale writes appear afterwards.
